delay_timer_arbiter: RTL and testbench
======================================

// Module: delay_timer_arbiter
// PURPOSE
//  Shares one programmable delay counter among N requesters (UART TX/RX bit timers, timeouts).
//  A round-robin arbiter grants the counter to one requester at a time.
//  It then counts that requester's delay and returns a one-cycle Done pulse to it.
//  Sits between the UART control FSMs and the timing resource; replaces per-client delay loops.
// PARAMETERS
//  N   4   number of requesters (>=2)
//  DW  16  delay width in bits; Delay values 0..2^DW-1 clock cycles
// PORTS
//  Clock   in   1     system clock; all logic on posedge
//  MR_n    in   1     master reset, synchronous, active-low
//  Req     in   N     Req[i]=1: requester i wants a delay; held high until Done[i]
//  Delay   in   N*DW  packed delays; requester i uses Delay[i*DW +: DW]
//  Grant   out  N     one-hot owner of the counter; all-zero when idle
//  Done    out  N     one-cycle pulse to the owner at the end of its delay
//  Busy    out  1     1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (MR_n==0 at posedge): state=IDLE, Grant=0, Done=0, Busy=0, cnt=0, rr pointer=0.
//    Reset mid-operation aborts the delay and issues no Done.
//  - All outputs are registered.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE, Req!=0 at posedge:
//    - Winner w = first i with Req[i]==1, searching from the pointer upward with wrap.
//    - On that edge: Grant<=onehot(w), dly<=Delay[w] (sampled once; later changes ignored), cnt<=0, pointer<=(w+1)%N, ->RUN.
//  - IDLE, Req==0: stay in IDLE; outputs 0.
//  - RUN: each posedge, if cnt==dly -> DONE and Done[w]<=1; else cnt<=cnt+1.
//    - RUN lasts dly+1 cycles.
//    - Compare is equality only; cnt never wraps (dly=2^DW-1 is legal).
//  - DONE: lasts exactly 1 cycle with Grant[w]=1 and Done[w]=1. Next posedge: Grant<=0, Done<=0, ->IDLE.
//  - Total Grant high time = dly+2 cycles. Arbitration adds 1 idle cycle between back-to-back grants.
//  - Req[w] still high after Done: treated as a new request. Rotating priority serves other pending requesters first.
//  - Simultaneous requests: exactly one grant per arbitration. Losers wait with no starvation; worst-case wait is N-1 grants.
//  - Req[w] falling during RUN: behaviour set by CONFIGURATION.
// CONFIGURATION
//  Macro DELAY_ARB_ABORT_EN:
//   - Defined: in RUN, Req[w]==0 at posedge -> IDLE on that edge, Grant<=0, no Done. Pointer update stands.
//   - Undefined: Req is ignored while in RUN/DONE; the delay always completes and Done[w] fires.
// STRUCTURE
//  - Package delay_arb_pkg:
//    - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//    - default N and DW constants
//    - onehot/index helper function
//  - Sub-module rr_arbiter (combinational):
//    - inputs Req[N], pointer
//    - outputs valid, winner index
//    - instantiated once; FSM and counter live in the top.
// TESTING
//  1. MR_n=0 for 2 cycles with Req=4'b1111 -> Grant=0, Done=0, Busy=0 throughout; first grant after release goes to requester 0.
//  2. Req=4'b0010, Delay[1]=3 -> Grant=4'b0010 for 5 cycles; Done[1] high only in the 5th; Busy high for those 5 cycles.
//  3. Req=4'b1111 held, all Delay=0 -> grant order 0,1,2,3,0; each Grant lasts 2 cycles; 1 idle cycle between grants.
//  4. DW=4 override, Delay=15 -> Grant lasts 17 cycles, no early Done from wrap. Changing Delay mid-RUN has no effect.
//  5. Req[2], Delay=10; MR_n=0 in RUN at cnt=4 -> all outputs 0 next cycle; no Done[2] ever.
//  6. Req[0], Delay=8; drop Req[0] at cnt=3 -> ABORT_EN: Grant=0 next cycle, no Done. Undefined: Done[0] after 10 cycles total.

Source files
------------

// File: rtl/delay_arb_pkg.sv
// Shared types and helpers for the delay timer arbiter.
// State encoding, default sizing and the round-robin pointer step.
package delay_arb_pkg;

   localparam int N_DEF  = 4;
   localparam int DW_DEF = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // Index that follows idx, wrapping at n.
   function automatic int unsigned next_index(int unsigned idx, int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/delay_timer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, with wrap.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] winner
);

   logic [PW-1:0] sel;

   // Scanning from the far end lets the nearest candidate overwrite the others.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      valid  = 1'b0;
      winner = '0;
      sel    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sel = PW'((int'(ptr) + k) % N);
         if (req[sel]) begin
            valid  = 1'b1;
            winner = sel;
         end
      end
   end

endmodule

// File: rtl/delay_timer_arbiter.sv
// One delay counter shared round-robin among N requesters; Done pulses the owner.
// Optional DELAY_ARB_ABORT_EN: owner dropping Req during RUN abandons its delay.
module delay_timer_arbiter
   import delay_arb_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF
) (
   input  logic            Clock,
   input  logic            MR_n,
   input  logic [N-1:0]    Req,
   input  logic [N*DW-1:0] Delay,
   output logic [N-1:0]    Grant,
   output logic [N-1:0]    Done,
   output logic            Busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [N-1:0]  done_q, done_d;
   logic          busy_q, busy_d;
   logic [DW-1:0] dly_q, dly_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] own_q, own_d;
   logic          arb_valid;
   logic [PW-1:0] arb_winner;

   rr_arbiter #(.N(N), .PW(PW)) u_arb (
      .req    (Req),
      .ptr    (ptr_q),
      .valid  (arb_valid),
      .winner (arb_winner)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      dly_d   = dly_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (arb_valid) begin
               grant_d = ONE << arb_winner;
               dly_d   = Delay[int'(arb_winner)*DW +: DW];
               cnt_d   = '0;
               ptr_d   = PW'(next_index(int'(arb_winner), N));
               own_d   = arb_winner;
               state_d = RUN;
            end
         end
         RUN: begin
            // Equality compare only: cnt stops at dly, so dly = all-ones never wraps.
            if (cnt_q == dly_q) begin
               done_d  = ONE << own_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`ifdef DELAY_ARB_ABORT_EN
            if (!Req[own_q]) begin
               grant_d = '0;
               done_d  = '0;
               cnt_d   = cnt_q;
               state_d = IDLE;
            end
`endif
         end
         DONE: begin
            grant_d = '0;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clock) begin
      if (!MR_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         dly_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         own_q   <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         dly_q   <= dly_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
      end
   end

   assign Grant = grant_q;
   assign Done  = done_q;
   assign Busy  = busy_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Scoreboard bench for delay_timer_arbiter: per-cycle expectations queued, then compared.
module tb_delay_timer_arbiter;

   typedef struct packed {
      logic [3:0] g;
      logic [3:0] d;
      logic       b;
   } exp_t;

   logic        Clock = 1'b0;
   logic        MR_n;
   logic [3:0]  Req;
   logic [63:0] Delay;
   logic [3:0]  Grant, Done;
   logic        Busy;

   logic [3:0]  req4;
   logic [15:0] delay4;
   logic [3:0]  grant4, done4;
   logic        busy4;

   exp_t sb[$];
   exp_t e, act;
   int   checks = 0;
   int   errors = 0;

   always #5 Clock = ~Clock;

   delay_timer_arbiter #(.N(4), .DW(16)) dut (
      .Clock (Clock), .MR_n (MR_n), .Req (Req), .Delay (Delay),
      .Grant (Grant), .Done (Done), .Busy (Busy)
   );

   delay_timer_arbiter #(.N(4), .DW(4)) dut4 (
      .Clock (Clock), .MR_n (MR_n), .Req (req4), .Delay (delay4),
      .Grant (grant4), .Done (done4), .Busy (busy4)
   );

   task automatic push(input logic [3:0] g, input logic [3:0] d, input logic b);
      exp_t x;
      x.g = g; x.d = d; x.b = b;
      sb.push_back(x);
   endtask

   // Grant window: dly+1 RUN cycles, then one DONE cycle.
   task automatic push_window(input logic [3:0] oh, input int dly);
      for (int k = 0; k <= dly; k++) push(oh, 4'b0000, 1'b1);
      push(oh, oh, 1'b1);
   endtask

   task automatic push_idle(input int n);
      for (int k = 0; k < n; k++) push(4'b0000, 4'b0000, 1'b0);
   endtask

   task automatic test_reset();
      MR_n = 1'b0; Req = 4'b1111; Delay = '0; req4 = '0; delay4 = '0;
      push_idle(2);
      push_window(4'b0001, 0);
      push_idle(1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge Clock); #1;
         e = sb.pop_front(); act = {Grant, Done, Busy}; checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL reset cyc %0d got g=%b d=%b b=%b exp g=%b d=%b b=%b",
                     i, act.g, act.d, act.b, e.g, e.d, e.b);
         end
         if (i == 1) MR_n = 1'b1;
         if (sb.size() == 1) Req = 4'b0000;
      end
   endtask

   task automatic test_single();
      Req = 4'b0010; Delay[1*16 +: 16] = 16'd3;
      push_window(4'b0010, 3);
      push_idle(1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge Clock); #1;
         e = sb.pop_front(); act = {Grant, Done, Busy}; checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL single cyc %0d got g=%b d=%b b=%b exp g=%b d=%b b=%b",
                     i, act.g, act.d, act.b, e.g, e.d, e.b);
         end
         if (sb.size() == 1) Req = 4'b0000;
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] order [5];
      order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      MR_n = 1'b0; Req = 4'b1111; Delay = '0;
      push_idle(1);
      for (int k = 0; k < 5; k++) begin
         push_window(order[k], 0);
         push_idle(1);
      end
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge Clock); #1;
         e = sb.pop_front(); act = {Grant, Done, Busy}; checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL round_robin cyc %0d got g=%b d=%b b=%b exp g=%b d=%b b=%b",
                     i, act.g, act.d, act.b, e.g, e.d, e.b);
         end
         if (i == 0) MR_n = 1'b1;
         if (sb.size() == 1) Req = 4'b0000;
      end
   endtask

   task automatic test_max_delay();
      req4 = 4'b0001; delay4[0 +: 4] = 4'd15;
      push_window(4'b0001, 15);
      push_idle(1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge Clock); #1;
         e = sb.pop_front(); act = {grant4, done4, busy4}; checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL max_delay cyc %0d got g=%b d=%b b=%b exp g=%b d=%b b=%b",
                     i, act.g, act.d, act.b, e.g, e.d, e.b);
         end
         if (i == 4) delay4[0 +: 4] = 4'd2;
         if (sb.size() == 1) req4 = 4'b0000;
      end
   endtask

   task automatic test_reset_mid_run();
      Req = 4'b0100; Delay[2*16 +: 16] = 16'd10;
      for (int k = 0; k < 5; k++) push(4'b0100, 4'b0000, 1'b1);
      push_idle(14);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge Clock); #1;
         e = sb.pop_front(); act = {Grant, Done, Busy}; checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL reset_mid_run cyc %0d got g=%b d=%b b=%b exp g=%b d=%b b=%b",
                     i, act.g, act.d, act.b, e.g, e.d, e.b);
         end
         if (i == 4) MR_n = 1'b0;
         if (i == 5) begin MR_n = 1'b1; Req = 4'b0000; end
      end
   endtask

   task automatic test_req_drop();
      Req = 4'b0001; Delay[0 +: 16] = 16'd8;
`ifdef DELAY_ARB_ABORT_EN
      for (int k = 0; k < 4; k++) push(4'b0001, 4'b0000, 1'b1);
      push_idle(8);
`else
      push_window(4'b0001, 8);
      push_idle(2);
`endif
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge Clock); #1;
         e = sb.pop_front(); act = {Grant, Done, Busy}; checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL req_drop cyc %0d got g=%b d=%b b=%b exp g=%b d=%b b=%b",
                     i, act.g, act.d, act.b, e.g, e.d, e.b);
         end
         if (i == 3) Req = 4'b0000;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_max_delay();
      test_reset_mid_run();
      test_req_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
